// File: rtl/pkt_rx_port.sv
// Packet receive port: buffers incoming flits from a router output in a FIFO,
// strips the header flit into HDR and presents payload flits to the PE with
// SOF/EOF framing. Backpressure is raised when free space falls to SKID.
//
// Handshake: a payload flit transfers on Q in any cycle where Q_VALID and
// Q_READY are both 1; while Q_VALID=1 and Q_READY=0, Q/Q_SOF/Q_EOF hold.
// On the receive side there is no handshake: D is taken whenever D_VALID=1,
// and the router is expected to honour D_BP. A flit arriving at a full FIFO
// (with no pop that cycle) is dropped and ERR latches.
module pkt_rx_port #(
  parameter int DEPTH = 16,
  parameter int SKID  = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [63:0] D,
  input  logic        D_VALID,
  output logic        D_BP,
  output logic [63:0] Q,
  output logic        Q_VALID,
  input  logic        Q_READY,
  output logic        Q_SOF,
  output logic        Q_EOF,
  output logic [63:0] HDR,
  output logic        HDR_VALID,
  output logic        ERR,
  output logic [0:0]  dbg_state
);

  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] FULL_LVL = AW1'(DEPTH);
  localparam logic [AW:0] BP_LVL   = AW1'(DEPTH - SKID);

  localparam logic [0:0] HEAD = 1'b0;
  localparam logic [0:0] BODY = 1'b1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [0:0]    state;
  logic [15:0]   rem;
  logic          first;

  logic          fifo_empty;
  logic [63:0]   head_flit;
  logic          hdr_pop;
  logic          body_pop;
  logic          pop;
  logic          push;
  logic          drop;

  // FIFO flow control and pop decisions for header stripping and payload delivery
  always_comb begin
    fifo_empty = (count == '0);
    head_flit  = mem[rd_ptr];
    hdr_pop    = (state == HEAD) && !fifo_empty;
    body_pop   = (state == BODY) && !fifo_empty && Q_READY;
    pop        = hdr_pop || body_pop;
    push       = D_VALID && ((count != FULL_LVL) || pop);
    drop       = D_VALID && !push;
    unique case ({push, pop})
      2'b10:   count_next = count + AW1'(1);
      2'b01:   count_next = count - AW1'(1);
      default: count_next = count;
    endcase
  end

  // Payload presentation; Q is zeroed when nothing valid is shown
  always_comb begin
    Q_VALID   = (state == BODY) && !fifo_empty;
    Q         = Q_VALID ? head_flit : 64'd0;
    Q_SOF     = Q_VALID && first;
    Q_EOF     = Q_VALID && (rem == 16'd1);
    dbg_state = state;
  end

  // FIFO storage write; storage itself needs no reset since pointers are reset
  always_ff @(posedge CLK) begin
    if (RST_N && push) begin
      mem[wr_ptr] <= D;
    end
  end

  // FIFO pointers, occupancy, backpressure and sticky overflow flag
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      D_BP   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      D_BP  <= (count_next >= BP_LVL);
      if (drop) ERR <= 1'b1;
    end
  end

  // Parser FSM: HEAD consumes a header internally, BODY delivers LEN payload flits
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= HEAD;
      rem       <= 16'd0;
      first     <= 1'b0;
      HDR       <= 64'd0;
      HDR_VALID <= 1'b0;
    end else begin
      HDR_VALID <= hdr_pop;
      if (hdr_pop) begin
        HDR   <= head_flit;
        rem   <= head_flit[15:0];
        first <= 1'b1;
        state <= (head_flit[15:0] == 16'd0) ? HEAD : BODY;
      end else if (body_pop) begin
        rem   <= rem - 16'd1;
        first <= 1'b0;
        if (rem == 16'd1) state <= HEAD;
      end
    end
  end

endmodule

// File: tb/tb_pkt_rx_port.sv
// Directed testbench for pkt_rx_port (DEPTH=16, SKID=4).
module tb_pkt_rx_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] d = '0;
  logic        d_valid = 1'b0;
  logic        d_bp;
  logic [63:0] q;
  logic        q_valid;
  logic        q_ready = 1'b0;
  logic        q_sof;
  logic        q_eof;
  logic [63:0] hdr;
  logic        hdr_valid;
  logic        err;
  logic [0:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int hdr_cnt = 0;
  logic [65:0] rx_q[$];
  logic [65:0] exp_q[$];

  pkt_rx_port #(.DEPTH(16), .SKID(4)) dut (
    .CLK(clk), .RST_N(rst_n), .D(d), .D_VALID(d_valid), .D_BP(d_bp),
    .Q(q), .Q_VALID(q_valid), .Q_READY(q_ready), .Q_SOF(q_sof), .Q_EOF(q_eof),
    .HDR(hdr), .HDR_VALID(hdr_valid), .ERR(err), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // monitor: record accepted payload flits as {sof, eof, data} and header pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (q_valid && q_ready) rx_q.push_back({q_sof, q_eof, q});
      if (hdr_valid) hdr_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] f);
    d = f;
    d_valid = 1'b1;
    step();
    d_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; q_ready = 1'b1;
    d = 64'hDEAD_BEEF_0000_0004; d_valid = 1'b1;
    step(); step();
    checks++; if (d_bp !== 1'b0) begin failures++; $display("FAIL reset_d_bp got=%b exp=0", d_bp); end
    checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL reset_q_valid got=%b exp=0", q_valid); end
    checks++; if (q_sof !== 1'b0) begin failures++; $display("FAIL reset_q_sof got=%b exp=0", q_sof); end
    checks++; if (q_eof !== 1'b0) begin failures++; $display("FAIL reset_q_eof got=%b exp=0", q_eof); end
    checks++; if (hdr !== 64'd0) begin failures++; $display("FAIL reset_hdr got=%h exp=0", hdr); end
    checks++; if (hdr_valid !== 1'b0) begin failures++; $display("FAIL reset_hdr_valid got=%b exp=0", hdr_valid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
    d_valid = 1'b0;
    rst_n = 1'b1;
    step();
    checks++; if (hdr_valid !== 1'b0) begin failures++; $display("FAIL reset_ignored_d got=%b exp=0", hdr_valid); end
  endtask

  task automatic test_basic();
    q_ready = 1'b1;
    send(64'h1111_2222_0000_0003);
    d = 64'hA; d_valid = 1'b1;
    checks++; if (hdr_valid !== 1'b0) begin failures++; $display("FAIL basic_hv_t1 got=%b exp=0", hdr_valid); end
    step();
    d = 64'hB;
    checks++; if (hdr_valid !== 1'b1) begin failures++; $display("FAIL basic_hv_t2 got=%b exp=1", hdr_valid); end
    checks++; if (hdr !== 64'h1111_2222_0000_0003) begin failures++; $display("FAIL basic_hdr got=%h exp=%h", hdr, 64'h1111_2222_0000_0003); end
    checks++; if ({q_valid, q_sof, q_eof, q} !== {3'b110, 64'hA}) begin failures++; $display("FAIL basic_flit_a got=%b%b%b %h exp=110 a", q_valid, q_sof, q_eof, q); end
    step();
    d = 64'hC;
    checks++; if ({q_valid, q_sof, q_eof, q} !== {3'b100, 64'hB}) begin failures++; $display("FAIL basic_flit_b got=%b%b%b %h exp=100 b", q_valid, q_sof, q_eof, q); end
    checks++; if (hdr_valid !== 1'b0) begin failures++; $display("FAIL basic_hv_t3 got=%b exp=0", hdr_valid); end
    step();
    d_valid = 1'b0;
    checks++; if ({q_valid, q_sof, q_eof, q} !== {3'b101, 64'hC}) begin failures++; $display("FAIL basic_flit_c got=%b%b%b %h exp=101 c", q_valid, q_sof, q_eof, q); end
    step();
    checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL basic_idle_q_valid got=%b exp=0", q_valid); end
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL basic_state got=%b exp=0", dbg_state); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", err); end
  endtask

  task automatic test_hdr_only();
    rx_q.delete(); hdr_cnt = 0; q_ready = 1'b1;
    send(64'h0000_00AA_0000_0000);
    send(64'h0000_00BB_0000_0001);
    send(64'h0000_0000_1234_5678);
    repeat (6) step();
    checks++; if (hdr_cnt !== 2) begin failures++; $display("FAIL hdronly_pulses got=%0d exp=2", hdr_cnt); end
    checks++; if (hdr !== 64'h0000_00BB_0000_0001) begin failures++; $display("FAIL hdronly_hdr got=%h exp=bb00000001", hdr); end
    checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL hdronly_count got=%0d exp=1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      checks++; if (rx_q[0] !== {2'b11, 64'h0000_0000_1234_5678}) begin failures++; $display("FAIL hdronly_flit got=%h exp=%h", rx_q[0], {2'b11, 64'h0000_0000_1234_5678}); end
    end
  endtask

  task automatic test_backpressure();
    rx_q.delete(); exp_q.delete(); q_ready = 1'b0;
    send(64'h0000_0000_0000_0010);
    step(); step();
    checks++; if (dbg_state !== 1'b1) begin failures++; $display("FAIL bp_in_body got=%b exp=1", dbg_state); end
    for (int k = 1; k <= 20; k++) begin
      d = 64'h5000 + 64'(k); d_valid = 1'b1;
      step();
      if (k == 11) begin
        checks++; if (d_bp !== 1'b0) begin failures++; $display("FAIL bp_at_11 got=%b exp=0", d_bp); end
      end
      if (k == 12) begin
        checks++; if (d_bp !== 1'b1) begin failures++; $display("FAIL bp_at_12 got=%b exp=1", d_bp); end
      end
    end
    d_valid = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL bp_err got=%b exp=1", err); end
    checks++; if (q !== 64'h5001) begin failures++; $display("FAIL bp_q_held got=%h exp=5001", q); end
    q_ready = 1'b1;
    repeat (20) step();
    q_ready = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 0), (i == 15), 64'h5001 + 64'(i)});
    checks++; if (rx_q.size() !== 16) begin failures++; $display("FAIL bp_count got=%0d exp=16", rx_q.size()); end
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_flit_%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (d_bp !== 1'b0) begin failures++; $display("FAIL bp_released got=%b exp=0", d_bp); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL bp_err_sticky got=%b exp=1", err); end
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL bp_state got=%b exp=0", dbg_state); end
  endtask

  task automatic test_stall_toggle();
    logic        stalled;
    logic [65:0] prev;
    int          n_sof;
    int          n_eof;
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL toggle_err_cleared got=%b exp=0", err); end
    rx_q.delete(); exp_q.delete();
    stalled = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 0) begin d = 64'h0000_0000_0000_0008; d_valid = 1'b1; end
      else if (cyc <= 8) begin d = 64'h7000 + 64'(cyc - 1); d_valid = 1'b1; end
      else d_valid = 1'b0;
      q_ready = cyc[0];
      if (stalled) begin
        checks++;
        if (!q_valid || {q_sof, q_eof, q} !== prev) begin
          failures++; $display("FAIL toggle_stable got=%b %h exp=1 %h", q_valid, {q_sof, q_eof, q}, prev);
        end
      end
      stalled = q_valid && !q_ready;
      prev = {q_sof, q_eof, q};
      step();
    end
    d_valid = 1'b0; q_ready = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 0), (i == 7), 64'h7000 + 64'(i)});
    checks++; if (rx_q.size() !== 8) begin failures++; $display("FAIL toggle_count got=%0d exp=8", rx_q.size()); end
    n_sof = 0; n_eof = 0;
    for (int i = 0; i < rx_q.size(); i++) begin
      if (rx_q[i][65]) n_sof++;
      if (rx_q[i][64]) n_eof++;
      if (i < 8) begin
        checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL toggle_flit_%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
      end
    end
    checks++; if (n_sof !== 1) begin failures++; $display("FAIL toggle_sof_count got=%0d exp=1", n_sof); end
    checks++; if (n_eof !== 1) begin failures++; $display("FAIL toggle_eof_count got=%0d exp=1", n_eof); end
  endtask

  task automatic test_reset_mid_packet();
    rx_q.delete(); q_ready = 1'b0;
    send(64'h0000_0055_0000_0005);
    for (int i = 0; i < 5; i++) send(64'h9000 + 64'(i));
    q_ready = 1'b1;
    step(); step();
    q_ready = 1'b0;
    checks++; if (rx_q.size() !== 2) begin failures++; $display("FAIL mid_pre_count got=%0d exp=2", rx_q.size()); end
    rst_n = 1'b0; d = 64'h0000_0000_0000_0003; d_valid = 1'b1;
    step();
    checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL mid_q_valid got=%b exp=0", q_valid); end
    checks++; if ({q_sof, q_eof} !== 2'b00) begin failures++; $display("FAIL mid_sof_eof got=%b exp=00", {q_sof, q_eof}); end
    checks++; if (hdr !== 64'd0) begin failures++; $display("FAIL mid_hdr got=%h exp=0", hdr); end
    checks++; if ({hdr_valid, err, d_bp} !== 3'b000) begin failures++; $display("FAIL mid_flags got=%b exp=000", {hdr_valid, err, d_bp}); end
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL mid_state got=%b exp=0", dbg_state); end
    d_valid = 1'b0; rst_n = 1'b1;
    step();
    rx_q.delete(); hdr_cnt = 0; q_ready = 1'b1;
    send(64'h0000_0066_0000_0002);
    send(64'hA0A0);
    send(64'hB0B0);
    repeat (8) step();
    checks++; if (hdr_cnt !== 1) begin failures++; $display("FAIL mid_new_pulses got=%0d exp=1", hdr_cnt); end
    checks++; if (hdr !== 64'h0000_0066_0000_0002) begin failures++; $display("FAIL mid_new_hdr got=%h exp=6600000002", hdr); end
    checks++; if (rx_q.size() !== 2) begin failures++; $display("FAIL mid_new_count got=%0d exp=2", rx_q.size()); end
    if (rx_q.size() == 2) begin
      checks++; if (rx_q[0] !== {2'b10, 64'hA0A0}) begin failures++; $display("FAIL mid_new_flit0 got=%h exp=%h", rx_q[0], {2'b10, 64'hA0A0}); end
      checks++; if (rx_q[1] !== {2'b01, 64'hB0B0}) begin failures++; $display("FAIL mid_new_flit1 got=%h exp=%h", rx_q[1], {2'b01, 64'hB0B0}); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hdr_only();
    test_backpressure();
    test_stall_toggle();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pkt_rx_port.md
PKT_RX_PORT -- requirements
Module: pkt_rx_port

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, receive FIFO depth in 64-bit flits (power of 2, >= 8).
REQ-002 SHALL provide parameter SKID, default 4, free-entry threshold for backpressure (1 <= SKID < DEPTH).
REQ-003 SHALL have port CLK  input  1  single clock for all logic.
REQ-004 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port D  input  64  flit from router output port.
REQ-006 SHALL have port D_VALID  input  1  D carries a flit this cycle.
REQ-007 SHALL have port D_BP  output  1  backpressure to router; 1 = stop sending.
REQ-008 SHALL have port Q  output  64  payload flit to PE logic.
REQ-009 SHALL have port Q_VALID  output  1  Q holds a valid payload flit.
REQ-010 SHALL have port Q_READY  input  1  PE accepts Q this cycle.
REQ-011 SHALL have port Q_SOF  output  1  Q is first payload flit of a packet.
REQ-012 SHALL have port Q_EOF  output  1  Q is last payload flit of a packet.
REQ-013 SHALL have port HDR  output  64  header flit of the current packet.
REQ-014 SHALL have port HDR_VALID  output  1  one-cycle pulse when HDR is updated.
REQ-015 SHALL have port ERR  output  1  sticky overflow flag.

Function
REQ-016 Packet format SHALL be: one header flit, then LEN = header[15:0] payload flits; LEN = 0 means header-only packet.
REQ-017 When D_VALID = 1, D SHALL be written to the FIFO if occupancy < DEPTH or a pop occurs the same cycle; otherwise the flit SHALL be dropped and ERR set to 1.
REQ-018 D_BP SHALL be registered, equal to 1 in cycle t+1 iff occupancy after the cycle-t write/pop is >= DEPTH-SKID.
REQ-019 The parser SHALL be an FSM with states HEAD and BODY, in HEAD after reset.
REQ-020 In HEAD with FIFO non-empty: pop the head flit internally (never presented on Q), register it into HDR, pulse HDR_VALID next cycle, load 16-bit counter REM = header[15:0].
REQ-021 From HEAD: LEN = 0 SHALL stay HEAD; LEN > 0 SHALL go to BODY.
REQ-022 In BODY: Q_VALID = FIFO non-empty; Q = FIFO head flit; pop and decrement REM when Q_VALID and Q_READY.
REQ-023 Q_SOF SHALL be 1 while the first payload flit is on Q; Q_EOF SHALL be 1 while REM = 1 (both valid only with Q_VALID; LEN = 1 asserts both).
REQ-024 Popping the Q_EOF flit SHALL return FSM to HEAD; the next header SHALL be consumed no earlier than the following cycle.
REQ-025 Q, Q_SOF, Q_EOF SHALL remain stable while Q_VALID = 1 and Q_READY = 0.
REQ-026 Latency: header written at edge of cycle t -> popped in t+1 -> HDR/HDR_VALID visible t+2; payload flit written at t+1 -> Q_VALID no earlier than t+2.
REQ-027 Q_VALID SHALL be 0 in HEAD; Q_READY in HEAD SHALL have no effect.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL count 0..DEPTH.
REQ-029 ERR SHALL be cleared only by reset; a dropped flit SHALL not alter REM or FSM state.

Reset
REQ-030 With RST_N = 0 at a rising CLK edge: FIFO empty, FSM HEAD, REM = 0, D_BP = 0, Q_VALID = 0, Q_SOF = 0, Q_EOF = 0, HDR = 0, HDR_VALID = 0, ERR = 0.
REQ-031 Reset mid-packet SHALL discard all buffered flits and partial packet state; the first flit after reset release SHALL be treated as a header.
REQ-032 D_VALID while RST_N = 0 SHALL be ignored.

Verification
REQ-033 Header LEN=3, payload A,B,C back-to-back, Q_READY=1 -> HDR_VALID pulse at t+2, Q=A (SOF), B, C (EOF) on consecutive cycles, ERR=0.
REQ-034 Header LEN=0 followed by header LEN=1 + payload X -> two HDR_VALID pulses, one Q flit X with SOF=EOF=1.
REQ-035 DEPTH=16, SKID=4, Q_READY=0, 20 flits streamed -> D_BP=1 one cycle after occupancy reaches 12; flits 17..20 dropped, ERR=1.
REQ-036 Q_READY toggling 1/0 during LEN=8 packet -> all 8 flits delivered in order, Q stable during stalls, exactly one SOF and one EOF.
REQ-037 RST_N=0 asserted after 2 of LEN=5 payload flits delivered -> all outputs at reset values next cycle; new header LEN=2 after release delivers exactly 2 flits.
